// File: rtl/ysyx_22040088_imem.sv
// ---------------------------------------------------------------------------
// ysyx_22040088_imem
// Instruction-memory responder sitting at the far end of the fetch interface.
// One fetch request (byte pc) is accepted at a time over a valid/ready
// handshake. The 32-bit word is returned LATENCY cycles after the accept
// edge and held until the consumer takes it. A backdoor write port preloads
// programs, and a 64-bit counter tallies completed response handshakes.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous reset, active-high
//   req_valid  : fetch request present
//   req_ready  : responder can accept a request this cycle
//   req_addr   : fetch byte address (pc)
//   rsp_valid  : response present
//   rsp_ready  : consumer accepts the response this cycle
//   rsp_inst   : instruction word (0 when rsp_err)
//   rsp_err    : request was misaligned or out of range
//   wr_en      : backdoor word write enable
//   wr_addr    : backdoor write byte address
//   wr_data    : backdoor write data
//   fetch_cnt  : number of completed response handshakes (wraps)
// ---------------------------------------------------------------------------
module ysyx_22040088_imem #(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [63:0] fetch_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Word-aligned, at or above BASE, and inside the array.
  function automatic logic addr_ok(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && (a >= BASE) && (off[63:2] < 62'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return off[IDX_W+1:2];
  endfunction

  logic [31:0]      r_mem [DEPTH];
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_pend_inst;
  logic             r_pend_err;
  logic [31:0]      r_rsp_inst;
  logic             r_rsp_err;
  logic [63:0]      r_fetch_cnt;

  logic             w_req_ok;
  logic [IDX_W-1:0] w_req_idx;
  logic [31:0]      w_rd_data;
  logic             w_wr_ok;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_req_ok  = addr_ok(req_addr);
  assign w_req_idx = addr_idx(req_addr);
  assign w_rd_data = w_req_ok ? r_mem[w_req_idx] : 32'h0;
  assign w_wr_ok   = addr_ok(wr_addr);
  assign w_wr_idx  = addr_idx(wr_addr);

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_inst  = r_rsp_inst;
  assign rsp_err   = r_rsp_err;
  assign fetch_cnt = r_fetch_cnt;

  // Backdoor write port. The array is never reset. A write landing on the
  // accept edge of the same word is seen by the read as the old value,
  // because the read snapshot and this write both use non-blocking updates.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && w_wr_ok) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  // Fetch FSM. The read data is snapshotted at the accept edge; for
  // LATENCY > 1 it waits in a pending register so the visible response
  // outputs keep their previous values until rsp_valid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_inst  <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_fetch_cnt <= 64'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (LATENCY == 1) begin
              r_rsp_inst <= w_rd_data;
              r_rsp_err  <= !w_req_ok;
              r_state    <= S_RESP;
            end else begin
              r_pend_inst <= w_rd_data;
              r_pend_err  <= !w_req_ok;
              r_cnt       <= 4'(LATENCY - 1);
              r_state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rsp_inst <= r_pend_inst;
            r_rsp_err  <= r_pend_err;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_fetch_cnt <= r_fetch_cnt + 64'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_imem.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040088_imem
// Directed bench for the instruction-memory responder. Three instances share
// clock, reset, address and backdoor write signals: index 0 has LATENCY=1,
// index 1 LATENCY=4, index 2 LATENCY=3. Each has its own handshake signals.
// ---------------------------------------------------------------------------
module tb_ysyx_22040088_imem;

  logic        clk;
  logic        rst;
  logic [63:0] req_addr;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  req_valid;
  logic [2:0]  rsp_ready;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] rsp_inst  [3];
  logic [63:0] fetch_cnt [3];

  int n_cmp;
  int n_bad;

  ysyx_22040088_imem #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .fetch_cnt(fetch_cnt[0]));

  ysyx_22040088_imem #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .fetch_cnt(fetch_cnt[1]));

  ysyx_22040088_imem #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_inst(rsp_inst[2]), .rsp_err(rsp_err[2]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .fetch_cnt(fetch_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [63:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bd_write(input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // One complete fetch on instance k with the given latency.
  task automatic fetch(input int k, input int lat, input logic [63:0] a,
                       input logic [31:0] ei, input logic ee, input string nm);
    @(negedge clk);
    chk({nm, ".req_ready"}, 64'(req_ready[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_addr     = a;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    req_valid[k] = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({nm, ".wait_valid"}, 64'(rsp_valid[k]), 64'd0);
      @(negedge clk);
    end
    chk({nm, ".rsp_valid"}, 64'(rsp_valid[k]), 64'd1);
    chk({nm, ".rsp_inst"}, 64'(rsp_inst[k]), 64'(ei));
    chk({nm, ".rsp_err"}, 64'(rsp_err[k]), 64'(ee));
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk({nm, ".valid_drop"}, 64'(rsp_valid[k]), 64'd0);
    chk({nm, ".ready_back"}, 64'(req_ready[k]), 64'd1);
  endtask

  vec_t        vt [7];
  logic [31:0] bb_words [3];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req_addr = 64'h0;
    wr_en = 1'b0;
    wr_addr = 64'h0;
    wr_data = 32'h0;
    req_valid = 3'b000;
    rsp_ready = 3'b000;

    vt[0] = '{64'h8000_0000, 32'h0000_0413, 1'b0};
    vt[1] = '{64'h8000_0004, 32'h00a0_0093, 1'b0};
    vt[2] = '{64'h8000_0002, 32'h0000_0000, 1'b1};
    vt[3] = '{64'h8000_0ffc, 32'hcafe_f00d, 1'b0};
    vt[4] = '{64'h7fff_fffc, 32'h0000_0000, 1'b1};
    vt[5] = '{64'h8000_0014, 32'h1111_1111, 1'b0};
    vt[6] = '{64'h8000_1000, 32'h0000_0000, 1'b1};
    bb_words[0] = 32'h0010_0113;
    bb_words[1] = 32'h0020_0193;
    bb_words[2] = 32'h0030_0213;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.fetch_cnt", fetch_cnt[0], 64'd0);
    chk("rst.rsp_inst", 64'(rsp_inst[0]), 64'd0);
    chk("rst.rsp_err", 64'(rsp_err[0]), 64'd0);
    rst = 1'b0;

    // Preload, including an out-of-range write that must be dropped
    bd_write(64'h8000_0000, 32'h0000_0413);
    bd_write(64'h8000_0004, 32'h00a0_0093);
    bd_write(64'h8000_0008, bb_words[0]);
    bd_write(64'h8000_000c, bb_words[1]);
    bd_write(64'h8000_0010, bb_words[2]);
    bd_write(64'h8000_0014, 32'h1111_1111);
    bd_write(64'h8000_0ffc, 32'hcafe_f00d);
    bd_write(64'h8000_1000, 32'hffff_ffff);
    bd_write(64'h8000_0001, 32'heeee_eeee);

    // Table-driven single fetches, LATENCY=1
    for (int i = 0; i < 7; i++) begin
      fetch(0, 1, vt[i].addr, vt[i].inst, vt[i].err, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.fetch_cnt", i), fetch_cnt[0], 64'(i + 1));
    end

    // LATENCY=4 with a 3-cycle consumer stall and a write during the stall
    @(negedge clk);
    chk("l4.req_ready", 64'(req_ready[1]), 64'd1);
    req_valid[1] = 1'b1;
    req_addr = 64'h8000_0004;
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("l4.c%0d.valid", c), 64'(rsp_valid[1]), 64'd0);
      chk($sformatf("l4.c%0d.ready", c), 64'(req_ready[1]), 64'd0);
      @(negedge clk);
    end
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("l4.stall%0d.valid", s), 64'(rsp_valid[1]), 64'd1);
      chk($sformatf("l4.stall%0d.inst", s), 64'(rsp_inst[1]), 64'h00a0_0093);
      chk($sformatf("l4.stall%0d.err", s), 64'(rsp_err[1]), 64'd0);
      if (s == 1) begin
        wr_en = 1'b1;
        wr_addr = 64'h8000_0004;
        wr_data = 32'h0bad_bad0;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    chk("l4.hs.valid", 64'(rsp_valid[1]), 64'd1);
    chk("l4.hs.inst", 64'(rsp_inst[1]), 64'h00a0_0093);
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    chk("l4.after.valid", 64'(rsp_valid[1]), 64'd0);
    chk("l4.after.ready", 64'(req_ready[1]), 64'd1);
    chk("l4.after.fetch_cnt", fetch_cnt[1], 64'd1);
    chk("l4.after.hold_inst", 64'(rsp_inst[1]), 64'h00a0_0093);
    @(negedge clk);
    chk("l4.after2.fetch_cnt", fetch_cnt[1], 64'd1);
    fetch(1, 4, 64'h8000_0004, 32'h0bad_bad0, 1'b0, "l4.new");

    // Read-before-write on the accept edge
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr = 64'h8000_0014;
    wr_en = 1'b1;
    wr_addr = 64'h8000_0014;
    wr_data = 32'hdead_beef;
    @(negedge clk);
    req_valid[0] = 1'b0;
    wr_en = 1'b0;
    chk("rbw.valid", 64'(rsp_valid[0]), 64'd1);
    chk("rbw.old_inst", 64'(rsp_inst[0]), 64'h1111_1111);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    fetch(0, 1, 64'h8000_0014, 32'hdead_beef, 1'b0, "rbw.new");

    // Reset during WAIT on the LATENCY=3 instance
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_addr = 64'h8000_0000;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("mrst.wait_valid", 64'(rsp_valid[2]), 64'd0);
    rst = 1'b1;
    #1;
    chk("mrst.ready_in_rst", 64'(req_ready[2]), 64'd0);
    @(negedge clk);
    chk("mrst.rst.valid", 64'(rsp_valid[2]), 64'd0);
    chk("mrst.rst.ready", 64'(req_ready[2]), 64'd0);
    chk("mrst.rst.fetch_cnt", fetch_cnt[2], 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mrst.post%0d.valid", c), 64'(rsp_valid[2]), 64'd0);
      chk($sformatf("mrst.post%0d.ready", c), 64'(req_ready[2]), 64'd1);
    end
    chk("mrst.fetch_cnt_still0", fetch_cnt[2], 64'd0);
    rsp_ready[2] = 1'b0;
    fetch(2, 3, 64'h8000_0000, 32'h0000_0413, 1'b0, "mrst.reload");
    chk("mrst.fetch_cnt1", fetch_cnt[2], 64'd1);
    chk("mrst.l1_cnt_cleared", fetch_cnt[0], 64'd0);

    // Back-to-back requests on LATENCY=1, req_valid held high
    @(negedge clk);
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    req_addr = 64'h8000_0008;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("b2b.c%0d.ready", c), 64'(req_ready[0]), 64'((c % 2) == 0));
      chk($sformatf("b2b.c%0d.valid", c), 64'(rsp_valid[0]), 64'((c % 2) == 1));
      if ((c % 2) == 1) begin
        chk($sformatf("b2b.c%0d.inst", c), 64'(rsp_inst[0]), 64'(bb_words[c / 2]));
        req_addr = req_addr + 64'd4;
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    chk("b2b.fetch_cnt", fetch_cnt[0], 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
